// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce scheduler.
//   state_e  : scheduler state encoding (IDLE / COUNT)
//   rr_pick  : round-robin pick, first set request bit at or after a pointer
package debounce_pkg;

  // Widest channel vector the round-robin helper handles
  localparam int unsigned CH_MAX   = 16;
  localparam int unsigned CH_IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // First set bit of req[n-1:0] scanning upward from ptr, wrapping modulo n.
  // ptr must be below n; returns 0 when req is empty.
  function automatic int unsigned rr_pick(input logic [CH_MAX-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < CH_MAX; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i < n) && req[idx[CH_IDX_W-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/debounce_scheduler_if.sv
// Pin-side bundle of the debounce scheduler.
//   iSig    : raw asynchronous inputs          (master -> slave)
//   oSignal : debounced levels                 (slave -> master)
//   oL2H    : one-cycle rise pulse per channel (slave -> master)
//   oH2L    : one-cycle fall pulse per channel (slave -> master)
//   oBusy   : window counter granted           (slave -> master)
//   oChan   : granted channel, 0 when idle     (slave -> master)
interface debounce_scheduler_if #(
  parameter int unsigned CH_NUM = 4
) ();
  localparam int unsigned CHAN_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [CH_NUM-1:0] iSig;
  logic [CH_NUM-1:0] oSignal;
  logic [CH_NUM-1:0] oL2H;
  logic [CH_NUM-1:0] oH2L;
  logic              oBusy;
  logic [CHAN_W-1:0] oChan;

  modport master (
    output iSig,
    input  oSignal, oL2H, oH2L, oBusy, oChan
  );

  modport slave (
    input  iSig,
    output oSignal, oL2H, oH2L, oBusy, oChan
  );
endinterface

// File: rtl/sig_sync_edge.sv
// Per-channel two-flop synchroniser plus delay flop for edge detection.
//   CLK      : system clock
//   RST_n    : async active-low reset
//   sig_i    : raw asynchronous input
//   sync_o   : synchronised level (second sync flop)
//   edge_o_c : combinational change flag, sync level differs from its delayed copy
module sig_sync_edge (
  input  logic CLK,
  input  logic RST_n,
  input  logic sig_i,
  output logic sync_o,
  output logic edge_o_c
);
  logic s1_q;
  logic s2_q;
  logic d_q;

  // Metastability chain followed by the edge-compare delay stage
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      d_q  <= s2_q;
    end
  end

  assign sync_o   = s2_q;
  assign edge_o_c = s2_q ^ d_q;
endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel debouncer sharing one stability-window counter.
// Changed channels queue as pending; a round-robin scheduler grants the
// counter to one at a time and commits its level after FILTER_NUM stable
// cycles, pulsing oL2H/oH2L when the committed level changes.
//   CLK   : system clock, rising edge
//   RST_n : async active-low reset
//   bus   : debounce_scheduler_if.slave (iSig in; oSignal/oL2H/oH2L/oBusy/oChan out)
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned FILTER_NUM = 10,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 CLK,
  input logic                 RST_n,
  debounce_scheduler_if.slave bus
);
  localparam int unsigned      CHAN_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_NUM - 1);
  localparam logic [CHAN_W-1:0] CH_LAST = CHAN_W'(CH_NUM - 1);

  logic [CH_NUM-1:0] s2_vec;
  logic [CH_NUM-1:0] edge_vec;
  logic [CHAN_W-1:0] pick_idx;

  state_e            state_q, state_d;
  logic [CHAN_W-1:0] chan_q,  chan_d;
  logic              level_q, level_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [CH_NUM-1:0] pend_q,  pend_d;
  logic [CHAN_W-1:0] rr_q,    rr_d;
  logic [CH_NUM-1:0] sig_q,   sig_d;
  logic [CH_NUM-1:0] l2h_q,   l2h_d;
  logic [CH_NUM-1:0] h2l_q,   h2l_d;

  // Per-channel synchroniser and edge detector
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    sig_sync_edge u_sync (
      .CLK      (CLK),
      .RST_n    (RST_n),
      .sig_i    (bus.iSig[g]),
      .sync_o   (s2_vec[g]),
      .edge_o_c (edge_vec[g])
    );
  end

  // Next channel to serve among the pending ones
  assign pick_idx = CHAN_W'(rr_pick(CH_MAX'(pend_q), 32'(rr_q), CH_NUM));

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      chan_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      sig_q   <= '0;
      l2h_q   <= '0;
      h2l_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      sig_q   <= sig_d;
      l2h_q   <= l2h_d;
      h2l_q   <= h2l_d;
    end
  end

  // Scheduler next-state, window counter and commit logic
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    sig_d   = sig_q;
    l2h_d   = '0;
    h2l_d   = '0;
    pend_d  = pend_q | edge_vec;

    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          chan_d           = pick_idx;
          level_d          = s2_vec[pick_idx];
          cnt_d            = '0;
          pend_d[pick_idx] = 1'b0;
          state_d          = COUNT;
        end
      end

      COUNT: begin
        // The granted channel's own edges restart its window, never re-queue it
        pend_d[chan_q] = 1'b0;
        if (edge_vec[chan_q]) begin
          cnt_d   = '0;
          level_d = s2_vec[chan_q];
        end else if (cnt_q == CNT_LAST) begin
          sig_d[chan_q] = level_q;
          l2h_d[chan_q] = level_q & ~sig_q[chan_q];
          h2l_d[chan_q] = ~level_q & sig_q[chan_q];
          rr_d          = (chan_q == CH_LAST) ? '0 : chan_q + 1'b1;
          chan_d        = '0;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.oSignal = sig_q;
  assign bus.oL2H    = l2h_q;
  assign bus.oH2L    = h2l_q;
  assign bus.oBusy   = (state_q == COUNT);
  assign bus.oChan   = chan_q;
endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed plus randomized bench for debounce_scheduler (CH_NUM=4, FILTER_NUM=10).
// A timestamp-based reference model predicts every output each cycle.
module tb_debounce_scheduler;
  import debounce_pkg::*;

  localparam int CH = 4;
  localparam int FN = 10;

  logic CLK;
  logic RST_n;
  int   checks;
  int   failures;

  debounce_scheduler_if #(.CH_NUM(CH)) bus ();

  debounce_scheduler #(
    .CH_NUM     (CH),
    .FILTER_NUM (FN),
    .CNT_W      (16)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  logic [CH-1:0] m_s1, m_s2, m_d;
  logic [CH-1:0] m_pend, m_sig, m_l2h, m_h2l;
  logic          m_level;
  int            m_gnt;
  int            m_rr;
  int            m_t;
  int            m_win_start;
  logic [CH-1:0] pulse_seen;
  logic [CH-1:0] cur;
  logic [CH-1:0] flip;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_d = '0;
    m_pend = '0; m_sig = '0; m_l2h = '0; m_h2l = '0;
    m_level = 1'b0; m_gnt = -1; m_rr = 0; m_t = 0; m_win_start = 0;
  endtask

  // One clock of the model: window start is a timestamp, commit once
  // FN clocks have elapsed since it with no change on the granted channel.
  task automatic model_step(input logic [CH-1:0] smp);
    logic [CH-1:0] chg;
    logic [CH-1:0] lvl;
    logic [CH-1:0] nxt_pend;
    chg      = m_s2 ^ m_d;
    lvl      = m_s2;
    nxt_pend = m_pend | chg;
    m_l2h    = '0;
    m_h2l    = '0;
    if (m_gnt < 0) begin
      if (m_pend != '0) begin
        for (int k = 0; k < CH; k++)
          if (m_gnt < 0 && m_pend[(m_rr + k) % CH]) m_gnt = (m_rr + k) % CH;
        m_level          = lvl[m_gnt];
        m_win_start      = m_t;
        nxt_pend[m_gnt]  = 1'b0;
      end
    end else begin
      nxt_pend[m_gnt] = 1'b0;
      if (chg[m_gnt]) begin
        m_win_start = m_t;
        m_level     = lvl[m_gnt];
      end else if (m_t - m_win_start == FN) begin
        if (m_level != m_sig[m_gnt]) begin
          if (m_level) m_l2h[m_gnt] = 1'b1;
          else         m_h2l[m_gnt] = 1'b1;
        end
        m_sig[m_gnt] = m_level;
        m_rr         = (m_gnt + 1) % CH;
        m_gnt        = -1;
      end
    end
    m_pend = nxt_pend;
    m_d    = m_s2;
    m_s2   = m_s1;
    m_s1   = smp;
    m_t++;
  endtask

  task automatic check_model();
    check_eq("oSignal", 32'(bus.oSignal), 32'(m_sig));
    check_eq("oL2H",    32'(bus.oL2H),    32'(m_l2h));
    check_eq("oH2L",    32'(bus.oH2L),    32'(m_h2l));
    check_eq("oBusy",   32'(bus.oBusy),   (m_gnt >= 0) ? 32'd1 : 32'd0);
    check_eq("oChan",   32'(bus.oChan),   (m_gnt >= 0) ? 32'(m_gnt) : 32'd0);
    check_eq("rr_ptr",  32'(dut.rr_q),    32'(m_rr));
  endtask

  // Drive one input value for one clock, then compare at the falling edge
  task automatic tick(input logic [CH-1:0] val);
    bus.iSig = val;
    @(posedge CLK);
    model_step(val);
    @(negedge CLK);
    pulse_seen = pulse_seen | bus.oL2H | bus.oH2L;
    check_model();
  endtask

  task automatic do_reset(input logic [CH-1:0] val);
    bus.iSig = val;
    RST_n    = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_oSignal", 32'(bus.oSignal), 32'd0);
    check_eq("rst_oL2H",    32'(bus.oL2H),    32'd0);
    check_eq("rst_oH2L",    32'(bus.oH2L),    32'd0);
    check_eq("rst_oBusy",   32'(bus.oBusy),   32'd0);
    check_eq("rst_oChan",   32'(bus.oChan),   32'd0);
    RST_n      = 1'b1;
    pulse_seen = '0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    pulse_seen = '0;
    bus.iSig   = '0;
    RST_n      = 1'b1;
    #1;

    // All inputs high through reset: sequential commits 0,1,2,3 eleven clocks apart
    do_reset(4'hF);
    for (int c = 0; c < 50; c++) begin
      int unsigned done;
      tick(4'hF);
      done = (c < 13) ? 0 : (((c - 13) / 11 + 1 > 4) ? 4 : (c - 13) / 11 + 1);
      check_eq("seq_commit", 32'(bus.oSignal), (32'd1 << done) - 32'd1);
    end

    // Clean rise on channel 0: busy clocks 3..12, commit and pulse at 13
    do_reset(4'h0);
    for (int c = 0; c < 13; c++) begin
      tick(4'h1);
      check_eq("busy_win", 32'(bus.oBusy), (c >= 3) ? 32'd1 : 32'd0);
      check_eq("chan_win", 32'(bus.oChan), 32'd0);
    end
    tick(4'h1);
    check_eq("rise0_sig", 32'(bus.oSignal), 32'h1);
    check_eq("rise0_l2h", 32'(bus.oL2H),    32'h1);
    repeat (10) tick(4'h1);

    // Four-cycle glitch on channel 1 is filtered silently
    pulse_seen = '0;
    repeat (4)  tick(4'h3);
    repeat (40) tick(4'h1);
    check_eq("glitch_sig",   32'(bus.oSignal), 32'h1);
    check_eq("glitch_pulse", 32'(pulse_seen),  32'h0);

    // Channel 2 bounces mid-window; commit lands FN clocks after the restart
    repeat (9)  tick(4'h5);
    repeat (2)  tick(4'h1);
    repeat (12) tick(4'h5);
    check_eq("bounce_pre",  32'(bus.oSignal), 32'h1);
    tick(4'h5);
    check_eq("bounce_sig",  32'(bus.oSignal), 32'h5);
    check_eq("bounce_l2h",  32'(bus.oL2H),    32'h4);

    // Channels 1 and 3 rise together: ch1 at 13, ch3 at 24
    do_reset(4'h0);
    repeat (13) tick(4'hA);
    check_eq("dual_pre", 32'(bus.oSignal), 32'h0);
    tick(4'hA);
    check_eq("dual_ch1", 32'(bus.oSignal), 32'h2);
    check_eq("dual_rr",  32'(dut.rr_q),    32'd2);
    repeat (11) tick(4'hA);
    check_eq("dual_ch3",     32'(bus.oSignal), 32'hA);
    check_eq("dual_ch3_l2h", 32'(bus.oL2H),    32'h8);

    // Asynchronous reset while counting at cnt=5
    do_reset(4'h0);
    repeat (9) tick(4'h1);
    check_eq("mid_cnt", 32'(dut.cnt_q), 32'd5);
    bus.iSig = 4'h0;
    RST_n    = 1'b0;
    #1;
    check_eq("async_busy", 32'(bus.oBusy),   32'd0);
    check_eq("async_sig",  32'(bus.oSignal), 32'd0);
    check_eq("async_pend", 32'(dut.pend_q),  32'd0);
    check_eq("async_chan", 32'(bus.oChan),   32'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST_n      = 1'b1;
    pulse_seen = '0;
    repeat (30) tick(4'h0);
    check_eq("post_rst_pulse", 32'(pulse_seen), 32'h0);

    // Randomized toggling, alternating bouncy and calm stretches
    cur = 4'($urandom);
    do_reset(cur);
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < CH; c++)
        flip[c] = ($urandom_range(0, ((n % 300) < 150) ? 5 : 20) == 0);
      cur = cur ^ flip;
      tick(cur);
    end
    repeat (60) tick(cur);
    check_eq("settle", 32'(bus.oSignal), 32'(cur));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
